// File: rtl/spi_accel_if.sv
// spi_accel_if: bundles the SPI pins, the XYZ sample handshake and the
// register-write notification of the accelerometer responder.
//   master modport : SPI master / sample source / write observer side
//   slave  modport : spi_accel_responder side
interface spi_accel_if;
  logic        spi_SCLK;
  logic        spi_SS_n;
  logic        spi_MOSI;
  logic        spi_MISO;
  logic        spi_MISO_oe;
  logic        g_sensor_int;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_x;
  logic [15:0] sample_y;
  logic [15:0] sample_z;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  modport master (
    output spi_SCLK, spi_SS_n, spi_MOSI, sample_valid, sample_x, sample_y, sample_z,
    input  spi_MISO, spi_MISO_oe, g_sensor_int, sample_ready, wr_strobe, wr_addr, wr_data, busy
  );

  modport slave (
    input  spi_SCLK, spi_SS_n, spi_MOSI, sample_valid, sample_x, sample_y, sample_z,
    output spi_MISO, spi_MISO_oe, g_sensor_int, sample_ready, wr_strobe, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/spi_accel_responder.sv
// spi_accel_responder: SPI mode-3 slave emulating an ADXL345-style 64x8
// register file. SCLK/SS_n/MOSI are oversampled on clk_clk; a command byte
// (RW, MB, addr[5:0]) is followed by data bytes with optional auto-increment.
// XYZ samples arrive on a valid/ready handshake and raise DATA_READY.
// Ports:
//   clk_clk      system clock (rising edge)
//   reset_reset  synchronous active-high reset
//   bus          spi_accel_if.slave: SPI pins, sample handshake, wr_* notify, busy
module spi_accel_responder #(
  parameter logic [7:0] DEVID_VALUE = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  spi_accel_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;
  state_t state, state_nxt;

  // Input synchronizers. SCLK/SS_n reset to their idle-high level so no
  // spurious edge is seen when reset releases.
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_sync <= '1;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0],   bus.spi_SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_MOSI};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;
  assign ss_rise   =  ss_s   & ~ss_d;
  assign ss_fall   = ~ss_s   &  ss_d;

  logic [7:0] regs [64];
  logic [2:0] bit_cnt;
  logic [7:0] shift_in, shift_out;
  logic [5:0] addr;        // address of the next byte to load or write
  logic       cmd_rw, cmd_mb;
  logic       data_ready;
  logic       miso;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  function automatic logic is_ro(input logic [5:0] a);
    return (a == 6'h00) || (a == 6'h30) || (a >= 6'h32 && a <= 6'h37);
  endfunction

  logic [7:0] byte_in;
  logic       byte_done, accept, load_en, dr_clr;
  logic [5:0] load_addr;
  logic [7:0] rd_byte;

  assign byte_in   = {shift_in[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !ss_rise;
  assign accept    = bus.sample_valid && (state == S_IDLE);

  // The first read byte is addressed straight from the incoming command.
  always_comb begin
    load_addr = (state == S_CMD) ? byte_in[5:0] : addr;
    load_en   = byte_done && (((state == S_CMD) && byte_in[7]) ||
                              ((state == S_DATA) && cmd_rw));
    rd_byte   = (load_addr == 6'h30) ? {data_ready, 7'b0} : regs[load_addr];
    dr_clr    = load_en && (load_addr >= 6'h32) && (load_addr <= 6'h37);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (ss_fall) state_nxt = S_CMD;
      S_CMD: begin
        if (ss_rise)        state_nxt = S_IDLE;
        else if (byte_done) state_nxt = S_DATA;
      end
      S_DATA: if (ss_rise) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      addr      <= '0;
      cmd_rw    <= 1'b0;
      cmd_mb    <= 1'b0;
      data_ready <= 1'b0;
      miso      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < 64; i++) regs[i] <= (i == 0) ? DEVID_VALUE : 8'h00;
    end else begin
      state     <= state_nxt;
      wr_strobe <= 1'b0;
      // An accept coinciding with a read-clear keeps DATA_READY set.
      data_ready <= accept | (data_ready & ~dr_clr);
      if (accept) begin
        regs[6'h32] <= bus.sample_x[7:0];
        regs[6'h33] <= bus.sample_x[15:8];
        regs[6'h34] <= bus.sample_y[7:0];
        regs[6'h35] <= bus.sample_y[15:8];
        regs[6'h36] <= bus.sample_z[7:0];
        regs[6'h37] <= bus.sample_z[15:8];
      end
      if (state == S_IDLE) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else if (ss_rise) begin
        miso <= 1'b0;
      end else begin
        if (sclk_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= byte_in;
        end
        if (sclk_fall && (state == S_DATA) && cmd_rw) begin
          miso      <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end
        if (byte_done && (state == S_CMD)) begin
          cmd_rw <= byte_in[7];
          cmd_mb <= byte_in[6];
          if (byte_in[7]) begin
            shift_out <= rd_byte;
            addr      <= byte_in[5:0] + {5'b0, byte_in[6]};
          end else begin
            addr <= byte_in[5:0];
          end
        end
        if (byte_done && (state == S_DATA)) begin
          addr <= addr + {5'b0, cmd_mb};
          if (cmd_rw) begin
            shift_out <= rd_byte;
          end else if (!is_ro(addr)) begin
            regs[addr] <= byte_in;
            wr_strobe  <= 1'b1;
            wr_addr    <= addr;
            wr_data    <= byte_in;
          end
        end
      end
    end
  end

  assign bus.spi_MISO     = miso;
  assign bus.spi_MISO_oe  = ~ss_s;
  assign bus.g_sensor_int = data_ready;
  assign bus.sample_ready = (state == S_IDLE);
  assign bus.wr_strobe    = wr_strobe;
  assign bus.wr_addr      = wr_addr;
  assign bus.wr_data      = wr_data;
  assign bus.busy         = (state != S_IDLE);

endmodule
